// File: rtl/lcd_fb_arbiter.sv
// lcd_fb_arbiter
//   Shares one single-port synchronous RGB565 frame-buffer RAM between the spi_lcd scan reader
//   (no handshake, re-fetched whenever its pixel address changes) and a req/ack draw client.
//   Contention between the two sides alternates so that neither starves.
// Ports
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_lcd_addr_x/y, o_lcd_data      scan pixel address in, registered pixel out
//   i_drw_req/we/x/y/wdata          draw request (level, operands held until ack)
//   o_drw_ack, o_drw_oob            one-cycle accept pulse, out-of-range flag with it
//   o_drw_rvalid, o_drw_rdata       read-data pulse, read data held until the next read
//   o_mem_en/we/addr/wdata          RAM control (combinational from state)
//   i_mem_rdata                     RAM read data, valid the cycle after a read
module lcd_fb_arbiter #(
  parameter int unsigned LCD_W  = 132,
  parameter int unsigned LCD_H  = 162,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_lcd_addr_x,
  input  logic [7:0]        i_lcd_addr_y,
  output logic [15:0]       o_lcd_data,
  input  logic              i_drw_req,
  input  logic              i_drw_we,
  input  logic [7:0]        i_drw_x,
  input  logic [7:0]        i_drw_y,
  input  logic [15:0]       i_drw_wdata,
  output logic              o_drw_ack,
  output logic              o_drw_oob,
  output logic              o_drw_rvalid,
  output logic [15:0]       o_drw_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  input  logic [15:0]       i_mem_rdata
);

  // 8-bit x/y with a width of at most 256 always fits in 16 bits, so the scan address is kept
  // untruncated for change detection.
  localparam int unsigned LinW = 16;

  typedef enum logic [2:0] {StIdle, StLcdRd, StLcdCap, StDrwOp, StDrwCap} state_e;

  state_e            r_state, w_state_d;
  logic [LinW-1:0]   r_lcd_q, r_seen_addr;
  logic              r_lcd_inr, r_seen_inr, r_seen_vld;
  logic              r_last_drw;
  logic              r_drw_inr;

  logic [LinW-1:0]   w_lcd_lin;
  logic              w_lcd_inr, w_lcd_pend;
  logic [ADDR_W-1:0] w_drw_addr;
  logic              w_drw_inr;

  assign w_lcd_lin  = LinW'(i_lcd_addr_y) * LinW'(LCD_W) + LinW'(i_lcd_addr_x);
  assign w_lcd_inr  = (32'(i_lcd_addr_x) < LCD_W) && (32'(i_lcd_addr_y) < LCD_H);
  // A change of in-range status alone also forces a refetch (address aliasing beyond the edge).
  assign w_lcd_pend = !r_seen_vld || (w_lcd_lin != r_seen_addr) || (w_lcd_inr != r_seen_inr);

  assign w_drw_addr = ADDR_W'(i_drw_y) * ADDR_W'(LCD_W) + ADDR_W'(i_drw_x);
  assign w_drw_inr  = (32'(i_drw_x) < LCD_W) && (32'(i_drw_y) < LCD_H);

  always_comb begin
    w_state_d   = r_state;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_drw_ack   = 1'b0;
    o_drw_oob   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_lcd_pend && i_drw_req) begin
          w_state_d = r_last_drw ? StLcdRd : StDrwOp;
        end else if (w_lcd_pend) begin
          w_state_d = StLcdRd;
        end else if (i_drw_req) begin
          w_state_d = StDrwOp;
        end
      end
      StLcdRd: begin
        if (r_lcd_inr) begin
          o_mem_en   = 1'b1;
          o_mem_addr = r_lcd_q[ADDR_W-1:0];
        end
        w_state_d = StLcdCap;
      end
      StLcdCap: w_state_d = StIdle;
      StDrwOp: begin
        o_drw_ack = 1'b1;
        if (w_drw_inr) begin
          o_mem_en    = 1'b1;
          o_mem_we    = i_drw_we;
          o_mem_addr  = w_drw_addr;
          o_mem_wdata = i_drw_wdata;
        end else begin
          o_drw_oob = 1'b1;
        end
        w_state_d = i_drw_we ? StIdle : StDrwCap;
      end
      StDrwCap: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_lcd_q      <= '0;
      r_lcd_inr    <= 1'b0;
      r_seen_addr  <= '0;
      r_seen_inr   <= 1'b0;
      r_seen_vld   <= 1'b0;
      r_last_drw   <= 1'b0;
      r_drw_inr    <= 1'b0;
      o_lcd_data   <= '0;
      o_drw_rdata  <= '0;
      o_drw_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      o_drw_rvalid <= (r_state == StDrwCap);
      // Scan address is captured on the way into StLcdRd so the RAM address is registered.
      if (r_state == StIdle) begin
        r_lcd_q   <= w_lcd_lin;
        r_lcd_inr <= w_lcd_inr;
      end
      if (r_state == StLcdCap) begin
        o_lcd_data  <= r_lcd_inr ? i_mem_rdata : 16'h0000;
        r_seen_addr <= r_lcd_q;
        r_seen_inr  <= r_lcd_inr;
        r_seen_vld  <= 1'b1;
        r_last_drw  <= 1'b0;
      end
      if (r_state == StDrwOp) begin
        r_last_drw <= 1'b1;
        r_drw_inr  <= w_drw_inr;
      end
      if (r_state == StDrwCap) begin
        o_drw_rdata <= r_drw_inr ? i_mem_rdata : 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
module tb_lcd_fb_arbiter;
  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        lcd_x = '0, lcd_y = '0;
  logic [15:0]       lcd_data;
  logic              drw_req = 1'b0, drw_we = 1'b0;
  logic [7:0]        drw_x = '0, drw_y = '0;
  logic [15:0]       drw_wdata = '0;
  logic              drw_ack, drw_oob, drw_rvalid;
  logic [15:0]       drw_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata = '0;

  lcd_fb_arbiter #(.LCD_W(132), .LCD_H(162), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_lcd_addr_x(lcd_x), .i_lcd_addr_y(lcd_y), .o_lcd_data(lcd_data),
    .i_drw_req(drw_req), .i_drw_we(drw_we), .i_drw_x(drw_x), .i_drw_y(drw_y),
    .i_drw_wdata(drw_wdata), .o_drw_ack(drw_ack), .o_drw_oob(drw_oob),
    .o_drw_rvalid(drw_rvalid), .o_drw_rdata(drw_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM model.
  logic [15:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One draw transaction from an idle client; latencies counted in negedge samples.
  task automatic drw_txn(input logic we, input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] wd, output int ack_lat, output logic oob,
                         output logic en, output logic mwe, output logic [ADDR_W-1:0] addr,
                         output logic [15:0] mwd, output int rv_lat, output logic [15:0] rd);
    @(posedge clk); #1;
    drw_we = we; drw_x = x; drw_y = y; drw_wdata = wd; drw_req = 1'b1;
    ack_lat = -1; oob = 1'b0; en = 1'b0; mwe = 1'b0; addr = '0; mwd = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (drw_ack) begin
        ack_lat = i; oob = drw_oob; en = mem_en; mwe = mem_we; addr = mem_addr; mwd = mem_wdata;
        break;
      end
    end
    @(posedge clk); #1;
    drw_req = 1'b0;
    rv_lat = -1; rd = '0;
    if (!we && ack_lat > 0) begin
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        if (drw_rvalid) begin
          rv_lat = i; rd = drw_rdata;
          break;
        end
      end
    end
  endtask

  // Move the scan address and watch the following 8 cycles for scan reads.
  task automatic scan_to(input logic [7:0] x, input logic [7:0] y, output int reads,
                         output logic [ADDR_W-1:0] addr);
    @(posedge clk); #1;
    lcd_x = x; lcd_y = y;
    reads = 0; addr = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_en && !mem_we) begin
        reads++; addr = mem_addr;
      end
    end
  endtask

  int                ack_lat, rv_lat, reads, n;
  logic              oob, en, mwe;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       mwd, rd;
  int                last_ack, min_gap, max_gap, reads_since, bad_reads, acks, k;
  logic              chg, drop, found;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 16'h0000;
    ram[0] = 16'hF800;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lcd_data", lcd_data, 16'h0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_drw_ack", drw_ack, 1'b0);
    check("rst_drw_rvalid", drw_rvalid, 1'b0);
    check("rst_drw_rdata", drw_rdata, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First scan fetch of (0,0)
    @(negedge clk);
    check("idle_mem_en", mem_en, 1'b0);
    @(negedge clk);
    check("scan0_mem_en", mem_en, 1'b1);
    check("scan0_mem_we", mem_we, 1'b0);
    check("scan0_addr", mem_addr, 0);
    @(negedge clk);
    check("scan0_data_early", lcd_data, 16'h0);
    @(negedge clk);
    check("scan0_data", lcd_data, 16'hF800);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_en) n++;
    end
    check("stable_no_mem", n, 0);

    // Draw write then read of (5,2)
    drw_txn(1'b1, 8'd5, 8'd2, 16'h07E0, ack_lat, oob, en, mwe, addr, mwd, rv_lat, rd);
    check("wr_ack_lat", ack_lat, 2);
    check("wr_oob", oob, 1'b0);
    check("wr_en", en, 1'b1);
    check("wr_we", mwe, 1'b1);
    check("wr_addr", addr, 269);
    check("wr_wdata", mwd, 16'h07E0);
    drw_txn(1'b0, 8'd5, 8'd2, 16'h0, ack_lat, oob, en, mwe, addr, mwd, rv_lat, rd);
    check("rd_ack_lat", ack_lat, 2);
    check("rd_we", mwe, 1'b0);
    check("rd_addr", addr, 269);
    check("rd_rv_lat", rv_lat, 2);
    check("rd_data", rd, 16'h07E0);
    check("rd_data_held", drw_rdata, 16'h07E0);

    // Scan coherence and out-of-range scan
    scan_to(8'd5, 8'd2, reads, addr);
    check("scan52_reads", reads, 1);
    check("scan52_addr", addr, 269);
    check("scan52_data", lcd_data, 16'h07E0);
    scan_to(8'd132, 8'd0, reads, addr);
    check("scan_x_oob_reads", reads, 0);
    check("scan_x_oob_data", lcd_data, 16'h0);
    scan_to(8'd0, 8'd0, reads, addr);
    check("scan00_data", lcd_data, 16'hF800);
    scan_to(8'd0, 8'd162, reads, addr);
    check("scan_y_oob_reads", reads, 0);
    check("scan_y_oob_data", lcd_data, 16'h0);

    // Draw corner and out-of-range
    drw_txn(1'b1, 8'd131, 8'd161, 16'hABCD, ack_lat, oob, en, mwe, addr, mwd, rv_lat, rd);
    check("corner_oob", oob, 1'b0);
    check("corner_en", en, 1'b1);
    check("corner_addr", addr, 21383);
    drw_txn(1'b1, 8'd132, 8'd0, 16'h1234, ack_lat, oob, en, mwe, addr, mwd, rv_lat, rd);
    check("oobwr_ack", ack_lat > 0, 1'b1);
    check("oobwr_oob", oob, 1'b1);
    check("oobwr_en", en, 1'b0);
    drw_txn(1'b0, 8'd131, 8'd161, 16'h0, ack_lat, oob, en, mwe, addr, mwd, rv_lat, rd);
    check("corner_rd", rd, 16'hABCD);
    drw_txn(1'b0, 8'd0, 8'd162, 16'h0, ack_lat, oob, en, mwe, addr, mwd, rv_lat, rd);
    check("oobrd_oob", oob, 1'b1);
    check("oobrd_en", en, 1'b0);
    check("oobrd_rv_lat", rv_lat, 2);
    check("oobrd_data", rd, 16'h0);

    // Contention: req held high while scan x changes every cycle
    @(posedge clk); #1;
    k = 0; drw_we = 1'b1; drw_x = 8'd0; drw_y = 8'd100; drw_wdata = 16'h1000; drw_req = 1'b1;
    last_ack = -1; min_gap = 1000; max_gap = 0; reads_since = 0; bad_reads = 0; acks = 0;
    chg = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      lcd_x = 8'(c); lcd_y = 8'd0;
      if (chg) begin
        k++; drw_x = 8'(k); drw_wdata = 16'h1000 + 16'(k); chg = 1'b0;
      end
      @(negedge clk);
      if (mem_en && !mem_we) reads_since++;
      if (drw_ack) begin
        if (last_ack >= 0) begin
          if (c - last_ack < min_gap) min_gap = c - last_ack;
          if (c - last_ack > max_gap) max_gap = c - last_ack;
          if (reads_since != 1) bad_reads++;
        end
        reads_since = 0; last_ack = c; acks++; chg = 1'b1;
        if (acks == 8) break;
      end
    end
    @(posedge clk); #1;
    drw_req = 1'b0;
    check("alt_acks", acks, 8);
    check("alt_min_gap", min_gap, 5);
    check("alt_max_gap", max_gap, 5);
    check("alt_scan_reads", bad_reads, 0);
    drw_txn(1'b0, 8'd3, 8'd100, 16'h0, ack_lat, oob, en, mwe, addr, mwd, rv_lat, rd);
    check("alt_readback", rd, 16'h1003);
    scan_to(8'd0, 8'd0, reads, addr);
    check("alt_scan00", lcd_data, 16'hF800);

    // Reset in the middle of a draw op
    @(posedge clk); #1;
    drw_we = 1'b1; drw_x = 8'd10; drw_y = 8'd10; drw_wdata = 16'h5555; drw_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (drw_ack) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_op_ack", found, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_mem_en", mem_en, 1'b0);
    check("mid_rst_ack", drw_ack, 1'b0);
    check("mid_rst_lcd_data", lcd_data, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0; reads = 0; drop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (drw_ack) begin
        acks++; drop = 1'b1;
      end
      if (mem_en && !mem_we) reads++;
      @(posedge clk); #1;
      if (drop) drw_req = 1'b0;
    end
    check("post_rst_acks", acks, 1);
    check("post_rst_scan_reads", reads, 1);
    check("post_rst_lcd_data", lcd_data, 16'hF800);
    drw_txn(1'b0, 8'd10, 8'd10, 16'h0, ack_lat, oob, en, mwe, addr, mwd, rv_lat, rd);
    check("post_rst_readback", rd, 16'h5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
